// File: rtl/mul_div_hilo_unit.sv
// rtl/mul_div_hilo_unit.sv - iterative shift-add multiplier owning the HI/LO pair
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_div_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WData,
  output logic             MulOp,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_MSUB  = 2'b11;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               neg_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mplier_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] p_final;
  logic [2*WIDTH-1:0] hilo_d;
  logic               run_last;

  // Magnitudes are unsigned, so 0x80000000 maps exactly to 2^(WIDTH-1).
  assign signed_op = (Op != OP_MULTU);
  assign a_mag     = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag     = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;
  assign mplier_d  = mplier_q >> 1;
  assign prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign p_final   = neg_q ? (~prod_q + 1'b1) : prod_q;

`ifdef MUL_EARLY_TERM_EN
  assign run_last = (cnt_q == CNT_W'(1)) || (mplier_d == '0);
`else
  assign run_last = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    hilo_d = p_final;
    case (op_q)
      OP_MADD: hilo_d = {hi_q, lo_q} + p_final;
      OP_MSUB: hilo_d = {hi_q, lo_q} - p_final;
      default: hilo_d = p_final;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_RUN;
      S_RUN:    if (run_last) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The stall must start in the launch cycle, hence the combinational Start term.
  always_comb begin
    MulOp = (state_q == S_IDLE && Start && !Reset) || (state_q == S_RUN);
    Done  = (state_q == S_FINISH) && !Reset;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MULT;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (HiWrite) hi_q <= WData;
          if (LoWrite) lo_q <= WData;
          if (Start) begin
            op_q     <= Op;
            neg_q    <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            prod_q   <= '0;
            cnt_q    <= CNT_W'(WIDTH);
          end
        end
        S_RUN: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - 1'b1;
        end
        S_FINISH: {hi_q, lo_q} <= hilo_d;
        default: ;
      endcase
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mul_div_hilo_unit.sv
// tb/tb_mul_div_hilo_unit.sv - self-checking bench for mul_div_hilo_unit
// Arithmetic reference model compared every cycle, plus directed literal checks.
module tb_mul_div_hilo_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] WData = '0;
  logic        MulOp, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  mul_div_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
    .MulOp(MulOp), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result from plain integer multiply, timing as a cycle count.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_p = '0;
  logic [1:0]  m_op = '0;
  int          m_run = 0;
  logic        m_fin = 1'b0;
  logic        m_valid = 1'b0;

  function automatic int run_len(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] bmag;
    int n;
    bmag = (op != 2'b01 && b[31]) ? (32'd0 - b) : b;
    n = 32;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (bmag[i]) n = i + 1;
`endif
    return n;
  endfunction

  function automatic logic [63:0] product(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint sa, sb;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b01) return ua * ub;
    return 64'(sa * sb);
  endfunction

  always @(posedge Clk) begin
    m_valid <= 1'b1;
    if (Reset) begin
      m_hi <= '0; m_lo <= '0; m_run <= 0; m_fin <= 1'b0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
      case (m_op)
        2'b10:   {m_hi, m_lo} <= {m_hi, m_lo} + m_p;
        2'b11:   {m_hi, m_lo} <= {m_hi, m_lo} - m_p;
        default: {m_hi, m_lo} <= m_p;
      endcase
    end else if (m_run > 0) begin
      m_run <= m_run - 1;
      m_fin <= (m_run == 1);
    end else begin
      if (HiWrite) m_hi <= WData;
      if (LoWrite) m_lo <= WData;
      if (Start) begin
        m_op  <= Op;
        m_p   <= product(Op, A, B);
        m_run <= run_len(Op, B);
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("cmp_mulop", {63'd0, MulOp}, {63'd0, (m_run > 0) || (m_run == 0 && !m_fin && Start && !Reset)});
      chk("cmp_done", {63'd0, Done}, {63'd0, m_fin && !Reset});
      chk("cmp_hi", {32'd0, HI}, {32'd0, m_hi});
      chk("cmp_lo", {32'd0, LO}, {32'd0, m_lo});
    end
  end

  // Called just after a rising edge; launches in cycle 0 and optionally injects
  // a stray Start+HiWrite (kind 1) or a Reset (kind 2) during cycle ev_cyc.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic lw, input logic [31:0] wd, input int ev_cyc, input int ev_kind,
                       output int done_cyc, output int mulop_n, output int done_n);
    Op = op; A = a; B = b; Start = 1'b1; LoWrite = lw; WData = wd;
    done_cyc = -1; mulop_n = 0; done_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clk);
      if (MulOp) mulop_n++;
      if (Done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge Clk);
      #1;
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; Reset = 1'b0;
      if (done_cyc >= 0) break;
      if (ev_kind == 2 && c == ev_cyc) break;
      if (c + 1 == ev_cyc) begin
        if (ev_kind == 1) begin
          Start = 1'b1; A = 32'd7; B = 32'd7; HiWrite = 1'b1; WData = 32'hDEAD;
        end else if (ev_kind == 2) begin
          Reset = 1'b1;
        end
      end
    end
  endtask

  int dc, mc, dn;

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_hi", {32'd0, HI}, 64'd0);
    chk("reset_lo", {32'd0, LO}, 64'd0);
    chk("reset_mulop", {63'd0, MulOp}, 64'd0);
    @(posedge Clk); #1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("multu_max_done_cycle", 64'(dc), 64'd33);
    chk("multu_max_mulop_cycles", 64'(mc), 64'd33);
    chk("multu_max_hi", {32'd0, HI}, 64'hFFFFFFFE);
    chk("multu_max_lo", {32'd0, LO}, 64'h00000001);

    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("mult_neg3x5_hi", {32'd0, HI}, 64'hFFFFFFFF);
    chk("mult_neg3x5_lo", {32'd0, LO}, 64'hFFFFFFF1);

    do_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("mult_minneg_hi", {32'd0, HI}, 64'h40000000);
    chk("mult_minneg_lo", {32'd0, LO}, 64'h00000000);

    HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h55;
    @(posedge Clk); #1;
    chk("mthi_mtlo_both_hi", {32'd0, HI}, 64'h55);
    chk("mthi_mtlo_both_lo", {32'd0, LO}, 64'h55);
    HiWrite = 1'b1; LoWrite = 1'b0; WData = 32'd0;
    @(posedge Clk); #1;
    HiWrite = 1'b0;

    do_op(2'b10, 32'd2, 32'd3, 1'b1, 32'd10, -1, 0, dc, mc, dn);
    chk("madd_hi", {32'd0, HI}, 64'd0);
    chk("madd_lo", {32'd0, LO}, 64'd16);

    do_op(2'b11, 32'd4, 32'd5, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("msub_hi", {32'd0, HI}, 64'hFFFFFFFF);
    chk("msub_lo", {32'd0, LO}, 64'hFFFFFFFC);

    do_op(2'b00, 32'd3, 32'd4, 1'b0, 32'd0, 5, 1, dc, mc, dn);
    chk("restart_ignored_hi", {32'd0, HI}, 64'd0);
    chk("restart_ignored_lo", {32'd0, LO}, 64'd12);
    chk("restart_single_done", 64'(dn), 64'd1);

    do_op(2'b01, 32'h1234, 32'hFFFF0010, 1'b0, 32'd0, 10, 2, dc, mc, dn);
    chk("abort_no_done", 64'(dn), 64'd0);
    @(negedge Clk);
    chk("abort_mulop", {63'd0, MulOp}, 64'd0);
    chk("abort_hi", {32'd0, HI}, 64'd0);
    chk("abort_lo", {32'd0, LO}, 64'd0);
    @(posedge Clk); #1;

    do_op(2'b01, 32'd6, 32'd7, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("after_abort_lo", {32'd0, LO}, 64'd42);
    chk("after_abort_hi", {32'd0, HI}, 64'd0);

    do_op(2'b01, 32'd9, 32'd1, 1'b0, 32'd0, -1, 0, dc, mc, dn);
    chk("multu_9x1_lo", {32'd0, LO}, 64'd9);
`ifdef MUL_EARLY_TERM_EN
    chk("multu_9x1_done_cycle", 64'(dc), 64'd2);
`else
    chk("multu_9x1_done_cycle", 64'(dc), 64'd33);
`endif
    if (dc < 0) chk("done_timeout", 64'd0, 64'd1);

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
